// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt performance counters.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no entry held, out_valid=0
// ST_FULL  | main entry valid, skid empty
// ST_SKID  | main and skid both valid, upstream held off
module pipe_stage_reg #(
    parameter int unsigned       DATA_W          = 32,
    parameter bit                CLEAR_ON_BUBBLE = 1'b1,
    parameter logic [DATA_W-1:0] RESET_DATA      = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`else
    output logic [DATA_W-1:0] out_data
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    main_d  = in_data;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (in_valid) begin
                        main_d = in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (in_valid) begin
                    skid_d  = in_data;
                    state_d = ST_SKID;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_DATA;
            skid_d  = RESET_DATA;
        end
        // in_ready is precomputed from the next state so it can be registered
        in_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= RESET_DATA;
            skid_q     <= RESET_DATA;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);

    generate
        if (CLEAR_ON_BUBBLE) begin : g_clear
            assign out_data = out_valid ? main_q : '0;
        end else begin : g_hold
            assign out_data = main_q;
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Counters survive flush; only reset clears them. Wrap is natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!out_valid) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: scoreboard of accepted payloads plus
// directed scenarios; a second instance checks the CLEAR_ON_BUBBLE=0 variant.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic        h_in_ready, h_out_valid;
    logic [31:0] h_out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt, h_stall_cnt, h_bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_BUBBLE(1'b1), .RESET_DATA(32'h0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef PIPE_STAGE_PERF_EN
        .out_data(out_data), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`else
        .out_data(out_data)
`endif
    );

    pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_BUBBLE(1'b0), .RESET_DATA(32'h0)) dut_hold (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
        .out_valid(h_out_valid), .out_ready(out_ready),
`ifdef PIPE_STAGE_PERF_EN
        .out_data(h_out_data), .stall_cnt(h_stall_cnt), .bubble_cnt(h_bubble_cnt)
`else
        .out_data(h_out_data)
`endif
    );

    // Scoreboard monitor: transfers are decided by values stable mid-cycle.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got %h, expected no output", out_data);
                end else begin
                    logic [31:0] exp;
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        bad++;
                        $display("FAIL sb_order: got %h, expected %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h, expected 0 1 0",
                     out_valid, in_ready, out_data);
        end
        total++;
        if (h_out_valid !== 1'b0 || h_in_ready !== 1'b1 || h_out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_state_hold: valid=%b ready=%b data=%h, expected 0 1 0",
                     h_out_valid, h_in_ready, h_out_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        vals[0] = 32'h1000; vals[1] = 32'h1004; vals[2] = 32'h1008;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_%0d: valid=%b data=%h ready=%b, expected 1 %h 1",
                         i, out_valid, out_data, in_ready, vals[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL bubble_clear: valid=%b data=%h, expected 0 00000000", out_valid, out_data);
        end
        total++;
        if (h_out_valid !== 1'b0 || h_out_data !== 32'h1008) begin
            bad++;
            $display("FAIL bubble_hold: valid=%b data=%h, expected 0 00001008", h_out_valid, h_out_data);
        end
    endtask

    task automatic test_bubble_hold();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1234;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        total++;
        if (h_out_valid !== 1'b0 || h_out_data !== 32'h1234 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL bubble_1234: hvalid=%b hdata=%h data=%h, expected 0 00001234 00000000",
                     h_out_valid, h_out_data, out_data);
        end
    endtask

    task automatic test_skid_fill();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hAAAA || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL skid_first: valid=%b data=%h ready=%b, expected 1 0000aaaa 1",
                     out_valid, out_data, in_ready);
        end
        in_data = 32'hBBBB;
        tick();
        total++;
        if (out_data !== 32'hAAAA || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL skid_full: data=%h ready=%b, expected 0000aaaa 0", out_data, in_ready);
        end
        // offered while in_ready=0; must be ignored
        in_data   = 32'hDDDD;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hBBBB || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL skid_drain1: valid=%b data=%h ready=%b, expected 1 0000bbbb 1",
                     out_valid, out_data, in_ready);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL skid_drain2: valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_flush_skid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_pre: ready=%b, expected 0", in_ready);
        end
        flush   = 1'b1;
        in_data = 32'hCCCC;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || h_out_data !== 32'h0) begin
            bad++;
            $display("FAIL flush_skid: valid=%b data=%h ready=%b hdata=%h, expected 0 0 1 0",
                     out_valid, out_data, in_ready, h_out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_after_%0d: valid=%b data=%h, expected 0", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h33;
        tick();
        in_data = 32'h44;
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: valid=%b data=%h ready=%b, expected 0 0 1",
                     out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h55) begin
            bad++;
            $display("FAIL reset_mid_push: valid=%b data=%h, expected 1 00000055", out_valid, out_data);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_alone: valid=%b data=%h, expected 0", out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            total++;
            if (in_ready !== (sb.size() < 2) || out_valid !== (sb.size() != 0)) begin
                bad++;
                $display("FAIL b2b_occ_%0d: ready=%b valid=%b, expected entries=%0d",
                         i, in_ready, out_valid, sb.size());
            end
            if (sb.size() != 0) begin
                total++;
                if (out_data !== sb[0]) begin
                    bad++;
                    $display("FAIL b2b_head_%0d: data=%h, expected %h", i, out_data, sb[0]);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: valid=%b left=%0d, expected 0 0", out_valid, sb.size());
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            bad++;
            $display("FAIL perf_reset: stall=%0d bubble=%0d, expected 0 0", stall_cnt, bubble_cnt);
        end
        tick();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (stall_cnt !== 32'd3 || bubble_cnt !== 32'd3) begin
            bad++;
            $display("FAIL perf_count: stall=%0d bubble=%0d, expected 3 3", stall_cnt, bubble_cnt);
        end
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (stall_cnt !== 32'd3 || bubble_cnt !== 32'd3) begin
            bad++;
            $display("FAIL perf_flush: stall=%0d bubble=%0d, expected 3 3", stall_cnt, bubble_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_bubble_hold();
        test_skid_fill();
        test_flush_skid();
        test_reset_mid();
        test_back_to_back();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the flow CPU. It generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block.
- Carries an arbitrary-width payload bundle, for example instr, operands, imm, PC and control bits concatenated by the instantiating stage.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from a downstream stall does not need a combinational ready path to upstream.
- Supports flush for branch/jump squash. An invalid slot presents a bubble: all-zero payload, which is a NOP instruction.

Parameters:
DATA_W, 32, payload width in bits (1..1024)
CLEAR_ON_BUBBLE, 1, 1 = out_data forced to 0 whenever out_valid=0; 0 = out_data holds its last value
RESET_DATA, 0, value loaded into the payload registers on reset/flush (width DATA_W)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream presents a payload
in_ready  output  1  stage can accept this cycle; driven from a register, no combinational path from out_ready
in_data  input  DATA_W  upstream payload
out_valid  output  1  main entry is valid
out_ready  input  1  downstream consumes this cycle
out_data  output  DATA_W  main entry payload

Behaviour:
- Reset is synchronous and active-high on clk.
  - out_valid=0, out_data=RESET_DATA, in_ready=1.
  - Skid entry invalid; state EMPTY.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Latency from input transfer to out_valid is 1 cycle.
- State machine, based on entries held: EMPTY(0), FULL(1, main only), SKID(2, main+skid).
  - EMPTY: in_ready=1. in_valid -> main<=in_data, go to FULL. Otherwise stay.
  - FULL: in_ready=1.
    - out_ready & in_valid -> main<=in_data, stay FULL. This gives full throughput, one per cycle.
    - out_ready & !in_valid -> EMPTY.
    - !out_ready & in_valid -> skid<=in_data, go to SKID.
    - Neither -> hold.
  - SKID: in_ready=0, and in_valid is ignored.
    - out_ready -> main<=skid, go to FULL.
    - Otherwise hold both entries.
- in_ready is registered. It equals 0 only in SKID. It is also 1 immediately after reset and after a flush.
- flush:
  - Takes effect at the next edge, in any state. Result: EMPTY, main and skid payload <= RESET_DATA, out_valid=0.
  - A payload offered on the flush cycle is discarded even when in_ready=1.
  - Priority: reset > flush > normal transfers.
- out_data:
  - When out_valid=0 and CLEAR_ON_BUBBLE=1, out_data reads 0 (bubble), using combinational gating of the main register.
  - When CLEAR_ON_BUBBLE=0, out_data shows the main register unchanged.
- Ordering: payloads leave in exactly the order accepted. No drop and no duplication outside flush/reset.
- Reset or flush in SKID drops both entries. The following cycle shows in_ready=1.
- Protocol requirements:
  - Upstream must hold in_data stable while in_valid & !in_ready. The block does not check this.
  - out_data is stable while out_valid & !out_ready.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, two extra ports are present:
  - stall_cnt (output, 32): increments each cycle with out_valid & !out_ready.
  - bubble_cnt (output, 32): increments each cycle with out_valid=0.
- Counter behaviour: both wrap at 2^32-1 -> 0. Both clear on reset, not on flush.
- When undefined, these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Streaming: DATA_W=32, out_ready=1, push 0x1000,0x1004,0x1008 on consecutive cycles -> out_valid=1 each following cycle, same order, no gaps, in_ready stays 1.
- Skid fill: hold out_ready=0, push 0xAAAA then 0xBBBB -> out_data=0xAAAA, in_ready=0 after 2nd edge. Raise out_ready for 2 cycles -> 0xAAAA then 0xBBBB delivered, in_ready=1 after 1st drain.
- Flush in SKID: state SKID, assert flush with in_valid=1, in_data=0xCCCC -> next cycle out_valid=0, out_data=0, in_ready=1. 0xCCCC never appears.
- Bubble gating: CLEAR_ON_BUBBLE=1, empty stage -> out_data=0. With CLEAR_ON_BUBBLE=0, after delivering 0x1234 and draining -> out_data=0x1234, out_valid=0.
- Reset mid-operation: SKID with 2 entries, assert reset 1 cycle -> out_valid=0, out_data=RESET_DATA, in_ready=1. Next push of 0x55 appears alone.
- PIPE_STAGE_PERF_EN: after reset, 3 cycles stalled with out_valid=1 and 2 idle cycles -> stall_cnt=3, bubble_cnt counts every out_valid=0 cycle including post-reset cycles. Flush leaves both counts unchanged.
